// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline front-end registers.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Control word layout: {RegWrite, MemRd, MemWr, ALUSrc, ALUOp[3:0]}
    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMRD    = 6;
    localparam int CTRL_MEMWR    = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_ALUOP    = 0;   // LSB of the 4-bit ALUOp field
    localparam int CTRL_ALUOP_W  = 4;

endpackage

// File: rtl/pipe_front_regs_if.sv
// Bundle of hazard-control, ID-stage and front-end register signals.
interface pipe_front_regs_if #(
    parameter int CNT_W = 32
);
    import pipe_pkg::*;

    // hazard unit / fetch / decode side
    logic              PCWre;
    logic              IFID_Stall;
    logic              IDEX_Flush;
    logic              Redirect;
    logic [31:0]       RedirectPC;
    logic [31:0]       Instr_IF;
    logic [CTRL_W-1:0] Ctrl_ID;
    logic [4:0]        RsAddr_ID;
    logic [4:0]        RtAddr_ID;
    logic [4:0]        RegWriteAddr_ID;
    logic [31:0]       RsData_ID;
    logic [31:0]       RtData_ID;
    logic [31:0]       Imm_ID;

    // register outputs
    logic [31:0]       PC;
    logic [31:0]       Instr_IFID;
    logic [31:0]       PC4_IFID;
    logic              Valid_IFID;
    logic [CTRL_W-1:0] Ctrl_IDEX;
    logic [4:0]        RsAddr_IDEX;
    logic [4:0]        RtAddr_IDEX;
    logic [4:0]        RegWriteAddr_IDEX;
    logic [31:0]       RsData_IDEX;
    logic [31:0]       RtData_IDEX;
    logic [31:0]       Imm_IDEX;
    logic              Valid_IDEX;
    logic [CNT_W-1:0]  StallCnt;
    logic [CNT_W-1:0]  FlushCnt;
    logic              ProtoErr;

    modport master (
        output PCWre, IFID_Stall, IDEX_Flush, Redirect, RedirectPC, Instr_IF,
               Ctrl_ID, RsAddr_ID, RtAddr_ID, RegWriteAddr_ID,
               RsData_ID, RtData_ID, Imm_ID,
        input  PC, Instr_IFID, PC4_IFID, Valid_IFID, Ctrl_IDEX, RsAddr_IDEX,
               RtAddr_IDEX, RegWriteAddr_IDEX, RsData_IDEX, RtData_IDEX,
               Imm_IDEX, Valid_IDEX, StallCnt, FlushCnt, ProtoErr
    );

    modport slave (
        input  PCWre, IFID_Stall, IDEX_Flush, Redirect, RedirectPC, Instr_IF,
               Ctrl_ID, RsAddr_ID, RtAddr_ID, RegWriteAddr_ID,
               RsData_ID, RtData_ID, Imm_ID,
        output PC, Instr_IFID, PC4_IFID, Valid_IFID, Ctrl_IDEX, RsAddr_IDEX,
               RtAddr_IDEX, RegWriteAddr_IDEX, RsData_IDEX, RtData_IDEX,
               Imm_IDEX, Valid_IDEX, StallCnt, FlushCnt, ProtoErr
    );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: clear beats enable, both reload zeros.
module pipe_reg #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Async reset to zero; synchronous clear has priority over load.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers driven by hazard-unit controls,
// with saturating stall/squash counters and a sticky protocol-error flag.
module pipe_front_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter bit          DELAY_SLOT = 1'b0,
    parameter int          CNT_W      = 32
) (
    input logic              CLK,
    input logic              Reset,
    pipe_front_regs_if.slave bus
);

    localparam int IFID_W = 32 + 32 + 1;
    localparam int IDEX_W = CTRL_W + 5 + 5 + 5 + 32 + 32 + 32 + 1;

    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              squash;
    logic              ifid_en;
    logic              ifid_clr;
    logic              idex_clr;
    logic              proto_bad;
    logic [IFID_W-1:0] ifid_d;
    logic [IFID_W-1:0] ifid_q;
    logic [IDEX_W-1:0] idex_d;
    logic [IDEX_W-1:0] idex_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              proto_err;

    assign pc_plus4 = pc + 32'd4;

    // A redirect only squashes when the PC actually takes it and there is no delay slot.
    assign squash   = bus.Redirect && bus.PCWre && (DELAY_SLOT == 1'b0);

    // A stalled IF/ID must hold, so the squash clear is gated by the stall.
    assign ifid_en  = !bus.IFID_Stall;
    assign ifid_clr = !bus.IFID_Stall && squash;
    assign ifid_d   = {bus.Instr_IF, pc_plus4, 1'b1};

    // ID/EX is never held: it loads or takes an all-zero bubble every cycle.
    assign idex_clr = bus.IDEX_Flush || !bus.Valid_IFID;
    assign idex_d   = {bus.Ctrl_ID, bus.RsAddr_ID, bus.RtAddr_ID, bus.RegWriteAddr_ID,
                       bus.RsData_ID, bus.RtData_ID, bus.Imm_ID, 1'b1};

    // PC advancing must coincide with IF/ID advancing; a hold without a flush duplicates an instruction.
    assign proto_bad = (bus.PCWre == bus.IFID_Stall) || (bus.IFID_Stall && !bus.IDEX_Flush);

    pipe_reg #(.W(IFID_W)) u_ifid (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    pipe_reg #(.W(IDEX_W)) u_idex (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (1'b1),
        .clr   (idex_clr),
        .d     (idex_d),
        .q     (idex_q)
    );

    // Program counter: hold, redirect or sequential advance (wraps mod 2^32).
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc <= RESET_PC;
        end else if (bus.PCWre) begin
            pc <= bus.Redirect ? bus.RedirectPC : pc_plus4;
        end
    end

    // Saturating performance counters for stall cycles and IF/ID squashes.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!bus.PCWre && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_clr && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            proto_err <= 1'b0;
        end else if (proto_bad) begin
            proto_err <= 1'b1;
        end
    end

    assign bus.PC = pc;
    assign {bus.Instr_IFID, bus.PC4_IFID, bus.Valid_IFID} = ifid_q;
    assign {bus.Ctrl_IDEX, bus.RsAddr_IDEX, bus.RtAddr_IDEX, bus.RegWriteAddr_IDEX,
            bus.RsData_IDEX, bus.RtData_IDEX, bus.Imm_IDEX, bus.Valid_IDEX} = idex_q;
    assign bus.StallCnt = stall_cnt;
    assign bus.FlushCnt = flush_cnt;
    assign bus.ProtoErr = proto_err;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: two instances (squash / delay slot) driven in lockstep
// and compared every cycle against a behavioural model, plus directed tables.
module tb_pipe_front_regs;

    logic clk;
    logic rst;

    pipe_front_regs_if #(.CNT_W(4))  bus0();
    pipe_front_regs_if #(.CNT_W(32)) bus1();

    pipe_front_regs #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0), .CNT_W(4)) dut0 (
        .CLK(clk), .Reset(rst), .bus(bus0)
    );
    pipe_front_regs #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1), .CNT_W(32)) dut1 (
        .CLK(clk), .Reset(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // current stimulus
    bit          i_pcwre, i_stall, i_flush, i_redir;
    logic [31:0] i_rpc, i_instr, i_rsd, i_rtd, i_imm;
    logic [7:0]  i_ctrl;
    logic [4:0]  i_rs, i_rt, i_rwa;

    typedef struct {
        logic [31:0] pc, instr, pc4;
        bit          v_ifid;
        logic [7:0]  ctrl;
        logic [4:0]  rs, rt, rwa;
        logic [31:0] rsd, rtd, imm;
        bit          v_idex;
        longint      sc, fc;
        bit          perr;
    } st_t;

    st_t    m [2];
    longint cmax [2];
    bit     ds [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m[d] = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, v_ifid: 1'b0, ctrl: 8'h0,
                     rs: 5'h0, rt: 5'h0, rwa: 5'h0, rsd: 32'h0, rtd: 32'h0, imm: 32'h0,
                     v_idex: 1'b0, sc: 0, fc: 0, perr: 1'b0};
        end
    endfunction

    // Next state from the rules: PC hold/redirect/+4, IF/ID hold/squash/load,
    // ID/EX bubble/load, saturating counts, sticky error.
    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            st_t c = m[d];
            st_t n = m[d];
            bit  sq = i_redir && i_pcwre && !ds[d];
            if (i_pcwre) n.pc = i_redir ? i_rpc : c.pc + 32'd4;
            if (!i_stall) begin
                if (sq) begin
                    n.instr = 32'h0; n.pc4 = 32'h0; n.v_ifid = 1'b0;
                    if (c.fc < cmax[d]) n.fc = c.fc + 1;
                end else begin
                    n.instr = i_instr; n.pc4 = c.pc + 32'd4; n.v_ifid = 1'b1;
                end
            end
            if (i_flush || !c.v_ifid) begin
                n.ctrl = 8'h0; n.rs = 5'h0; n.rt = 5'h0; n.rwa = 5'h0;
                n.rsd = 32'h0; n.rtd = 32'h0; n.imm = 32'h0; n.v_idex = 1'b0;
            end else begin
                n.ctrl = i_ctrl; n.rs = i_rs; n.rt = i_rt; n.rwa = i_rwa;
                n.rsd = i_rsd; n.rtd = i_rtd; n.imm = i_imm; n.v_idex = 1'b1;
            end
            if (!i_pcwre && c.sc < cmax[d]) n.sc = c.sc + 1;
            if ((i_pcwre == i_stall) || (i_stall && !i_flush)) n.perr = 1'b1;
            m[d] = n;
        end
    endfunction

    task automatic drive(input bit pw, input bit st, input bit fl, input bit rd,
                         input logic [31:0] rpc, input logic [31:0] ins);
        i_pcwre = pw; i_stall = st; i_flush = fl; i_redir = rd; i_rpc = rpc; i_instr = ins;
        i_ctrl = 8'($urandom); i_rs = 5'($urandom); i_rt = 5'($urandom); i_rwa = 5'($urandom);
        i_rsd = $urandom; i_rtd = $urandom; i_imm = $urandom;
        bus0.PCWre = pw; bus0.IFID_Stall = st; bus0.IDEX_Flush = fl; bus0.Redirect = rd;
        bus0.RedirectPC = rpc; bus0.Instr_IF = ins; bus0.Ctrl_ID = i_ctrl;
        bus0.RsAddr_ID = i_rs; bus0.RtAddr_ID = i_rt; bus0.RegWriteAddr_ID = i_rwa;
        bus0.RsData_ID = i_rsd; bus0.RtData_ID = i_rtd; bus0.Imm_ID = i_imm;
        bus1.PCWre = pw; bus1.IFID_Stall = st; bus1.IDEX_Flush = fl; bus1.Redirect = rd;
        bus1.RedirectPC = rpc; bus1.Instr_IF = ins; bus1.Ctrl_ID = i_ctrl;
        bus1.RsAddr_ID = i_rs; bus1.RtAddr_ID = i_rt; bus1.RegWriteAddr_ID = i_rwa;
        bus1.RsData_ID = i_rsd; bus1.RtData_ID = i_rtd; bus1.Imm_ID = i_imm;
    endtask

    task automatic get_out(input int d, output st_t o);
        if (d == 0) begin
            o.pc = bus0.PC; o.instr = bus0.Instr_IFID; o.pc4 = bus0.PC4_IFID; o.v_ifid = bus0.Valid_IFID;
            o.ctrl = bus0.Ctrl_IDEX; o.rs = bus0.RsAddr_IDEX; o.rt = bus0.RtAddr_IDEX;
            o.rwa = bus0.RegWriteAddr_IDEX; o.rsd = bus0.RsData_IDEX; o.rtd = bus0.RtData_IDEX;
            o.imm = bus0.Imm_IDEX; o.v_idex = bus0.Valid_IDEX;
            o.sc = longint'(bus0.StallCnt); o.fc = longint'(bus0.FlushCnt); o.perr = bus0.ProtoErr;
        end else begin
            o.pc = bus1.PC; o.instr = bus1.Instr_IFID; o.pc4 = bus1.PC4_IFID; o.v_ifid = bus1.Valid_IFID;
            o.ctrl = bus1.Ctrl_IDEX; o.rs = bus1.RsAddr_IDEX; o.rt = bus1.RtAddr_IDEX;
            o.rwa = bus1.RegWriteAddr_IDEX; o.rsd = bus1.RsData_IDEX; o.rtd = bus1.RtData_IDEX;
            o.imm = bus1.Imm_IDEX; o.v_idex = bus1.Valid_IDEX;
            o.sc = longint'(bus1.StallCnt); o.fc = longint'(bus1.FlushCnt); o.perr = bus1.ProtoErr;
        end
    endtask

    task automatic compare_model();
        st_t o;
        for (int d = 0; d < 2; d++) begin
            get_out(d, o);
            chk($sformatf("dut%0d PC", d), o.pc, m[d].pc);
            chk($sformatf("dut%0d Instr_IFID", d), o.instr, m[d].instr);
            chk($sformatf("dut%0d PC4_IFID", d), o.pc4, m[d].pc4);
            chk($sformatf("dut%0d Valid_IFID", d), o.v_ifid, m[d].v_ifid);
            chk($sformatf("dut%0d IDEX fields", d),
                {o.ctrl, o.rs, o.rt, o.rwa, o.rsd[15:0], o.imm[15:0], o.v_idex},
                {m[d].ctrl, m[d].rs, m[d].rt, m[d].rwa, m[d].rsd[15:0], m[d].imm[15:0], m[d].v_idex});
            chk($sformatf("dut%0d IDEX data", d), {o.rsd, o.rtd}, {m[d].rsd, m[d].rtd});
            chk($sformatf("dut%0d IDEX imm", d), o.imm, m[d].imm);
            chk($sformatf("dut%0d StallCnt", d), o.sc, m[d].sc);
            chk($sformatf("dut%0d FlushCnt", d), o.fc, m[d].fc);
            chk($sformatf("dut%0d ProtoErr", d), o.perr, m[d].perr);
        end
    endtask

    // One clock: model advances on the same inputs, outputs sampled 1 time unit after the edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d pw=%0b st=%0b fl=%0b rd=%0b pc=%h ifid=%h v=%0b%0b sc=%0d fc=%0d perr=%0b",
                 cyc, i_pcwre, i_stall, i_flush, i_redir, bus0.PC, bus0.Instr_IFID,
                 bus0.Valid_IFID, bus0.Valid_IDEX, bus0.StallCnt, bus0.FlushCnt, bus0.ProtoErr);
        compare_model();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
    endtask

    typedef struct {
        bit          pw, st, fl, rd;
        logic [31:0] rpc;
        logic [31:0] exp_pc, exp_instr;
        bit          exp_vifid, exp_videx;
        int          exp_fc, exp_sc;
    } vec_t;

    vec_t vt [9];

    initial begin
        ds[0] = 1'b0; ds[1] = 1'b1;
        cmax[0] = 15; cmax[1] = 64'hFFFF_FFFF;

        // directed sequence for dut0 (squashing variant), starting from reset
        vt[0] = '{1,0,0,0, 32'h0,   32'h004, 32'hA000_0000, 1, 0, 0, 0};
        vt[1] = '{1,0,0,0, 32'h0,   32'h008, 32'hA000_0001, 1, 1, 0, 0};
        vt[2] = '{1,0,0,0, 32'h0,   32'h00C, 32'hA000_0002, 1, 1, 0, 0};
        vt[3] = '{0,1,1,0, 32'h0,   32'h00C, 32'hA000_0002, 1, 0, 0, 1};
        vt[4] = '{1,0,0,0, 32'h0,   32'h010, 32'hA000_0004, 1, 1, 0, 1};
        vt[5] = '{1,0,0,1, 32'h100, 32'h100, 32'h0000_0000, 0, 1, 1, 1};
        vt[6] = '{1,0,0,0, 32'h0,   32'h104, 32'hA000_0006, 1, 0, 1, 1};
        vt[7] = '{0,1,1,1, 32'h200, 32'h104, 32'hA000_0006, 1, 0, 1, 2};
        vt[8] = '{1,0,0,0, 32'h0,   32'h108, 32'hA000_0008, 1, 1, 1, 2};

        rst = 1'b1;
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        model_reset();
        #12;
        chk("reset PC", bus0.PC, 32'h0);
        chk("reset Valid_IFID", bus0.Valid_IFID, 1'b0);
        chk("reset Valid_IDEX", bus0.Valid_IDEX, 1'b0);
        chk("reset ProtoErr", bus0.ProtoErr, 1'b0);
        compare_model();
        rst = 1'b0;

        // reset during an active stall with PC at 0x40
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 0, 0, 32'h0, 32'hC000_0000 + k);
            step();
        end
        chk("free run PC 0x40", bus0.PC, 32'h40);
        drive(0, 1, 1, 0, 32'h0, 32'hDEAD_BEEF);
        step();
        chk("stall before reset StallCnt", bus0.StallCnt, 4'd1);
        pulse_reset();
        chk("async reset PC", bus0.PC, 32'h0);
        chk("async reset Valid_IFID", bus0.Valid_IFID, 1'b0);
        chk("async reset Valid_IDEX", bus0.Valid_IDEX, 1'b0);
        chk("async reset StallCnt", bus0.StallCnt, 4'd0);
        chk("async reset FlushCnt", bus0.FlushCnt, 4'd0);
        rst = 1'b0;
        drive(1, 0, 0, 0, 32'h0, 32'hA000_0000);

        // table: free run, load-use, redirect, dropped redirect
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].pw, vt[i].st, vt[i].fl, vt[i].rd, vt[i].rpc, 32'hA000_0000 + i);
            step();
            chk($sformatf("vec%0d PC", i), bus0.PC, vt[i].exp_pc);
            chk($sformatf("vec%0d Instr_IFID", i), bus0.Instr_IFID, vt[i].exp_instr);
            chk($sformatf("vec%0d Valid_IFID", i), bus0.Valid_IFID, vt[i].exp_vifid);
            chk($sformatf("vec%0d Valid_IDEX", i), bus0.Valid_IDEX, vt[i].exp_videx);
            chk($sformatf("vec%0d FlushCnt", i), bus0.FlushCnt, 4'(vt[i].exp_fc));
            chk($sformatf("vec%0d StallCnt", i), bus0.StallCnt, 4'(vt[i].exp_sc));
            chk($sformatf("vec%0d ProtoErr", i), bus0.ProtoErr, 1'b0);
            if (vt[i].rd && vt[i].pw) begin
                chk("delay slot Instr_IFID", bus1.Instr_IFID, 32'hA000_0000 + i);
                chk("delay slot Valid_IFID", bus1.Valid_IFID, 1'b1);
                chk("delay slot FlushCnt", bus1.FlushCnt, 32'd0);
                chk("delay slot PC", bus1.PC, vt[i].rpc);
            end
        end

        // illegal hold without flush: sticky error, then stall counter saturation
        drive(0, 1, 0, 0, 32'h0, 32'hB000_0000);
        step();
        chk("proto err set", bus0.ProtoErr, 1'b1);
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, 1, 0, 32'h0, 32'hB000_0001);
            step();
        end
        chk("StallCnt saturated", bus0.StallCnt, 4'hF);
        chk("proto err sticky", bus0.ProtoErr, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 32'h0, 32'hB000_0010 + k);
            step();
        end
        chk("proto err still sticky", bus0.ProtoErr, 1'b1);
        chk("StallCnt no wrap", bus0.StallCnt, 4'hF);

        // randomized traffic against the model
        pulse_reset();
        rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            int r = int'($urandom_range(0, 9));
            bit rd = ($urandom_range(0, 3) == 0);
            logic [31:0] tgt = {$urandom, 2'b00} ;
            if (k == 200) tgt = 32'hFFFF_FFF8;
            if (r <= 5)      drive(1, 0, 1'($urandom_range(0, 4) == 0), rd, tgt, $urandom);
            else if (r <= 7) drive(0, 1, 1, rd, tgt, $urandom);
            else if (r == 8) drive(1'($urandom), 1'($urandom), 1'($urandom), rd, tgt, $urandom);
            else             drive(1, 0, 0, 1, tgt, $urandom);
            step();
            if (k % 97 == 96) begin
                pulse_reset();
                compare_model();
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
